// File: rtl/accum_drain_ctrl.sv
// accum_drain_ctrl: drains one row at a time from the per-column accumulator
// FIFOs, saturates each word to OUT_WIDTH and streams the row out serially
// (column 0 first) over valid/ready. TILE_ROWS rows per start, then done.
module accum_drain_ctrl #(
    parameter int NUM_COLS   = 4,
    parameter int WORD_WIDTH = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int TILE_ROWS  = 4,
    parameter int COL_WIDTH  = 2,
    parameter int ROW_WIDTH  = 2
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    input  logic [NUM_COLS-1:0]              acc_empty,
    output logic [NUM_COLS-1:0]              acc_r_enable,
    input  logic [NUM_COLS*WORD_WIDTH-1:0]   acc_d_in,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [OUT_WIDTH-1:0]             m_data,
    output logic                             m_last,
    output logic                             sat_seen
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_POP,
        S_CAPT,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [COL_WIDTH-1:0] LAST_COL = COL_WIDTH'(NUM_COLS - 1);
    localparam logic [ROW_WIDTH-1:0] LAST_ROW = ROW_WIDTH'(TILE_ROWS - 1);
    localparam logic [OUT_WIDTH-1:0] SAT_MAX  = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] SAT_MIN  = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    state_t               state;
    state_t               state_nxt;
    logic [OUT_WIDTH-1:0] row_buf  [NUM_COLS];
    logic [OUT_WIDTH-1:0] sat_word [NUM_COLS];
    logic [NUM_COLS-1:0]  sat_hit;
    logic [COL_WIDTH-1:0] col;
    logic [ROW_WIDTH-1:0] row;
    logic                 start_acc;
    logic                 word_acc;
    logic                 row_end;

    assign start_acc = (state == S_IDLE) && start;
    assign word_acc  = (state == S_SEND) && m_ready;
    assign row_end   = word_acc && (col == LAST_COL);

    // Signed saturation per column: a word fits when its bits from OUT_WIDTH-1
    // upward are a pure sign extension; otherwise clamp toward its sign.
    always_comb begin
        for (int unsigned c = 0; c < NUM_COLS; c++) begin
            sat_word[c] = acc_d_in[c*WORD_WIDTH +: OUT_WIDTH];
            sat_hit[c]  = 1'b0;
            if (!(&acc_d_in[c*WORD_WIDTH + OUT_WIDTH - 1 +: WORD_WIDTH - OUT_WIDTH + 1]) &&
                 (|acc_d_in[c*WORD_WIDTH + OUT_WIDTH - 1 +: WORD_WIDTH - OUT_WIDTH + 1])) begin
                sat_hit[c]  = 1'b1;
                sat_word[c] = acc_d_in[c*WORD_WIDTH + WORD_WIDTH - 1] ? SAT_MIN : SAT_MAX;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_WAIT;
            S_WAIT: if (acc_empty == '0) state_nxt = S_POP;
            S_POP:  state_nxt = S_CAPT;
            S_CAPT: state_nxt = S_SEND;
            S_SEND: if (row_end) state_nxt = (row == LAST_ROW) ? S_DONE : S_WAIT;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy         = (state != S_IDLE);
        done         = (state == S_DONE);
        acc_r_enable = (state == S_POP) ? '1 : '0;
        m_valid      = (state == S_SEND);
        m_data       = m_valid ? row_buf[col] : '0;
        m_last       = m_valid && (col == LAST_COL) && (row == LAST_ROW);
    end

    // Row buffer capture, column/row counters and sticky saturation flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_buf  <= '{default: '0};
            col      <= '0;
            row      <= '0;
            sat_seen <= 1'b0;
        end else begin
            if (start_acc) begin
                col      <= '0;
                row      <= '0;
                sat_seen <= 1'b0;
            end
            if (state == S_CAPT) begin
                for (int unsigned c = 0; c < NUM_COLS; c++) begin
                    row_buf[c] <= sat_word[c];
                end
                if (|sat_hit) sat_seen <= 1'b1;
            end
            if (word_acc) begin
                if (row_end) begin
                    col <= '0;
                    row <= (row == LAST_ROW) ? '0 : row + ROW_WIDTH'(1);
                end else begin
                    col <= col + COL_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_accum_drain_ctrl.sv
// tb_accum_drain_ctrl: randomized scoreboard bench for accum_drain_ctrl with a
// queue-based accumulator FIFO model and an arithmetic saturation reference.
module tb_accum_drain_ctrl;

    localparam int NC  = 4;
    localparam int WW  = 32;
    localparam int OW  = 16;
    localparam int TR  = 2;
    localparam int WPT = NC * TR;
    localparam longint MAXV = (longint'(1) <<< (OW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (OW - 1));

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              busy;
    logic              done;
    logic [NC-1:0]     acc_empty = '1;
    logic [NC-1:0]     acc_r_enable;
    logic [NC*WW-1:0]  acc_d_in = '0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [OW-1:0]     m_data;
    logic              m_last;
    logic              sat_seen;

    typedef struct {
        logic [OW-1:0] data;
        bit            last;
        bit            sat;
    } exp_t;

    exp_t          exp_q[$];
    logic [WW-1:0] fifo[NC][$];
    int            vectors = 0;
    int            miscompares = 0;
    int            ren_pulses = 0;
    int            ready_mode = 0;
    int            tile_idx = 0;
    bit            tile_sat = 0;

    always #5 clk = ~clk;

    accum_drain_ctrl #(
        .NUM_COLS  (NC),
        .WORD_WIDTH(WW),
        .OUT_WIDTH (OW),
        .TILE_ROWS (TR),
        .COL_WIDTH (2),
        .ROW_WIDTH (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .acc_empty   (acc_empty),
        .acc_r_enable(acc_r_enable),
        .acc_d_in    (acc_d_in),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .sat_seen    (sat_seen)
    );

    function automatic void check(string name, longint act, longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    // Reference saturation from plain signed arithmetic
    function automatic bit ref_clamp(logic [WW-1:0] w);
        longint v = longint'($signed(w));
        return (v > MAXV) || (v < MINV);
    endfunction

    function automatic logic [OW-1:0] ref_sat(logic [WW-1:0] w);
        longint v = longint'($signed(w));
        if (v > MAXV) v = MAXV;
        else if (v < MINV) v = MINV;
        return v[OW-1:0];
    endfunction

    task automatic update_empty();
        for (int c = 0; c < NC; c++) acc_empty[c] = (fifo[c].size() == 0);
    endtask

    task automatic begin_tile();
        tile_idx   = 0;
        tile_sat   = 0;
        ren_pulses = 0;
    endtask

    // Queue one row: expected words go to the scoreboard, FIFO words only for masked columns
    task automatic add_row(input logic [WW-1:0] w[NC], input logic [NC-1:0] mask);
        for (int c = 0; c < NC; c++) if (ref_clamp(w[c])) tile_sat = 1;
        for (int c = 0; c < NC; c++) begin
            exp_t e;
            e.data = ref_sat(w[c]);
            e.last = (tile_idx == WPT - 1);
            e.sat  = tile_sat;
            exp_q.push_back(e);
            tile_idx++;
            if (mask[c]) fifo[c].push_back(w[c]);
        end
        update_empty();
    endtask

    task automatic rand_word(output logic [WW-1:0] w);
        int s;
        case ($urandom_range(0, 3))
            0: begin s = int'($urandom_range(0, 65535)) - 32768; w = WW'(s); end
            1: w = {1'b0, 31'($urandom)} | 32'h0001_0000;
            2: begin w = {1'b1, 31'($urandom)}; w[20] = 1'b0; end
            default: w = $urandom;
        endcase
    endtask

    task automatic add_rand_rows();
        logic [WW-1:0] r[NC];
        for (int i = 0; i < TR; i++) begin
            for (int c = 0; c < NC; c++) rand_word(r[c]);
            add_row(r, '1);
        end
    endtask

    // One clock: FIFO model pops on the sampled read enables, data valid next cycle
    task automatic tick();
        logic [NC-1:0] ren;
        ren = acc_r_enable;
        @(posedge clk);
        #1;
        if (ren != '0) begin
            ren_pulses++;
            check("ren_all_cols", ren, {NC{1'b1}});
            for (int c = 0; c < NC; c++) begin
                if (ren[c]) begin
                    if (fifo[c].size() == 0) check("pop_from_empty", 1, 0);
                    else acc_d_in[c*WW +: WW] = fifo[c].pop_front();
                end
            end
        end
        update_empty();
        case (ready_mode)
            0: m_ready = 1'b1;
            1: m_ready = ~m_ready;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!m_valid && n < budget) begin tick(); n++; end
        check("m_valid_timeout", n < budget, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin tick(); n++; end
        check("tile_timeout", n < budget, 1);
        check("words_left", exp_q.size(), 0);
        check("ren_pulses", ren_pulses, TR);
        tick();
    endtask

    // Monitor: compares accepted words against the scoreboard, checks hold and done timing
    initial begin
        bit            prev_stall = 0;
        logic [OW-1:0] prev_data = '0;
        bit            prev_last = 0;
        bit            expect_done = 0;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                check("reset_outputs",
                      {busy, done, acc_r_enable, m_valid, m_data, m_last, sat_seen}, 0);
                prev_stall  = 0;
                expect_done = 0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", m_valid, 1);
                    check("hold_data", m_data, prev_data);
                    check("hold_last", m_last, prev_last);
                end
                if (expect_done) begin
                    check("done_after_last", done, 1);
                    expect_done = 0;
                end else if (done) begin
                    check("unexpected_done", 1, 0);
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_word", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("m_data", m_data, e.data);
                        check("m_last", m_last, e.last);
                        check("sat_seen", sat_seen, e.sat);
                        if (e.last) expect_done = 1;
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
            end
        end
    end

    initial begin
        logic [WW-1:0] r[NC];
        logic [WW-1:0] held[TR];

        // Power-on reset
        tick(); tick();
        reset_n = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        // Sequential data, always ready, first-word latency
        ready_mode = 0;
        begin_tile();
        r = '{32'd1, 32'd2, 32'd3, 32'd4}; add_row(r, '1);
        r = '{32'd5, 32'd6, 32'd7, 32'd8}; add_row(r, '1);
        pulse_start();
        check("busy_after_start", busy, 1);
        tick(); tick();
        check("valid_not_early", m_valid, 0);
        tick();
        check("first_valid_latency", m_valid, 1);
        wait_idle(200);

        // Same data, alternating ready
        ready_mode = 1;
        begin_tile();
        r = '{32'd1, 32'd2, 32'd3, 32'd4}; add_row(r, '1);
        r = '{32'd5, 32'd6, 32'd7, 32'd8}; add_row(r, '1);
        pulse_start();
        wait_idle(200);

        // Saturation boundaries; sat_seen is sticky until the next start
        ready_mode = 2;
        begin_tile();
        r = '{32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_1234}; add_row(r, '1);
        r = '{32'h0000_7FFF, 32'hFFFF_8000, 32'h0000_8000, 32'hFFFF_7FFF}; add_row(r, '1);
        pulse_start();
        wait_idle(200);
        check("sat_sticky_idle", sat_seen, 1);

        // Column 2 held empty for 5 cycles; in-range data so sat_seen must clear
        begin_tile();
        for (int i = 0; i < TR; i++) begin
            for (int c = 0; c < NC; c++) r[c] = WW'(100 * i + c);
            held[i] = r[2];
            add_row(r, 4'b1011);
        end
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            check("wait_no_read", acc_r_enable, 0);
            check("wait_busy", busy, 1);
            tick();
        end
        check("wait_no_read_last", acc_r_enable, 0);
        for (int i = 0; i < TR; i++) fifo[2].push_back(held[i]);
        update_empty();
        tick();
        check("pop_after_fill", acc_r_enable, {NC{1'b1}});
        wait_idle(200);

        // start pulsed while streaming is ignored
        begin_tile();
        add_rand_rows();
        pulse_start();
        wait_valid(50);
        pulse_start();
        check("busy_ignore_start", busy, 1);
        wait_idle(200);

        // Reset mid-stream, then a clean tile
        begin_tile();
        add_rand_rows();
        pulse_start();
        wait_valid(50);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {busy, done, acc_r_enable, m_valid, m_data, m_last, sat_seen}, 0);
        for (int c = 0; c < NC; c++) fifo[c].delete();
        exp_q.delete();
        update_empty();
        tick(); tick();
        reset_n = 1'b1;
        tick();
        begin_tile();
        add_rand_rows();
        pulse_start();
        wait_idle(200);

        // Random tiles with random backpressure
        for (int t = 0; t < 8; t++) begin
            ready_mode = (t % 3 == 0) ? 0 : 2;
            begin_tile();
            add_rand_rows();
            pulse_start();
            wait_idle(300);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
